// File: rtl/hd_program_loader.sv
// Scans a streaming hard-disk image for the n-th begin-file marker and copies that
// program, through its end-file marker, into instruction memory starting at address 0.
module hd_program_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int IDX_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [IDX_WIDTH-1:0]  prog_idx,
   output logic [ADDR_WIDTH-1:0] hd_addr,
   input  logic [DATA_WIDTH-1:0] hd_q,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [DATA_WIDTH-1:0] im_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] prog_len
);

   typedef enum logic [2:0] {IDLE, SCAN, COPY, FIN, ERR} state_t;

   localparam logic [5:0]            OP_BEGIN = 6'b010101;
   localparam logic [5:0]            OP_END   = 6'b010110;
   localparam logic [5:0]            OP_HDEND = 6'b011000;
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] hd_addr_n;
   logic [ADDR_WIDTH-1:0] addr_p0, addr_p0_n;
   logic                  vld_p0, vld_p0_n;
   logic [ADDR_WIDTH-1:0] base, base_n;
   logic [IDX_WIDTH:0]    cnt, cnt_n;
   logic [IDX_WIDTH-1:0]  idx_q, idx_n;
   logic                  im_we_n;
   logic [ADDR_WIDTH-1:0] im_addr_n;
   logic [DATA_WIDTH-1:0] im_data_n;
   logic                  done_n, error_n;
   logic [ADDR_WIDTH-1:0] prog_len_n;
   logic [ADDR_WIDTH-1:0] rel;
   logic [5:0]            opcode;

   assign busy = (state == SCAN) || (state == COPY);

   always_comb begin
      state_n    = state;
      hd_addr_n  = hd_addr;
      // addr_p0 is the address whose word appears on hd_q at the next edge
      addr_p0_n  = hd_addr;
      vld_p0_n   = busy;
      base_n     = base;
      cnt_n      = cnt;
      idx_n      = idx_q;
      im_we_n    = 1'b0;
      im_addr_n  = im_addr;
      im_data_n  = im_data;
      done_n     = 1'b0;
      error_n    = 1'b0;
      prog_len_n = prog_len;
      rel        = addr_p0 - base;
      opcode     = hd_q[DATA_WIDTH-1 -: 6];

      case (state)
         IDLE: begin
            if (start) begin
               state_n    = SCAN;
               hd_addr_n  = '0;
               cnt_n      = '0;
               prog_len_n = '0;
               idx_n      = prog_idx;
            end
         end
         SCAN: begin
            hd_addr_n = hd_addr + 1'b1;
            if (vld_p0) begin
               if (opcode == OP_HDEND || addr_p0 == ADDR_LAST) begin
                  state_n = ERR;
                  error_n = 1'b1;
               end else if (opcode == OP_BEGIN) begin
                  if (cnt == {1'b0, idx_q}) begin
                     state_n   = COPY;
                     base_n    = addr_p0;
                     im_we_n   = 1'b1;
                     im_addr_n = '0;
                     im_data_n = hd_q;
                  end else if (cnt != '1) begin
                     cnt_n = cnt + 1'b1;
                  end
               end
            end
         end
         COPY: begin
            hd_addr_n = hd_addr + 1'b1;
            if (vld_p0) begin
               if (opcode == OP_BEGIN || opcode == OP_HDEND) begin
                  state_n = ERR;
                  error_n = 1'b1;
               end else if (opcode == OP_END) begin
                  state_n    = FIN;
                  im_we_n    = 1'b1;
                  im_addr_n  = rel;
                  im_data_n  = hd_q;
                  prog_len_n = rel + 1'b1;
               end else if (addr_p0 == ADDR_LAST) begin
                  // the image ran out of addresses without a terminator
                  state_n = ERR;
                  error_n = 1'b1;
               end else begin
                  im_we_n   = 1'b1;
                  im_addr_n = rel;
                  im_data_n = hd_q;
               end
            end
         end
         FIN: begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
         ERR: begin
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hd_addr  <= '0;
         addr_p0  <= '0;
         vld_p0   <= 1'b0;
         base     <= '0;
         cnt      <= '0;
         idx_q    <= '0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_data  <= '0;
         done     <= 1'b0;
         error    <= 1'b0;
         prog_len <= '0;
      end else begin
         state    <= state_n;
         hd_addr  <= hd_addr_n;
         addr_p0  <= addr_p0_n;
         vld_p0   <= vld_p0_n;
         base     <= base_n;
         cnt      <= cnt_n;
         idx_q    <= idx_n;
         im_we    <= im_we_n;
         im_addr  <= im_addr_n;
         im_data  <= im_data_n;
         done     <= done_n;
         error    <= error_n;
         prog_len <= prog_len_n;
      end
   end

endmodule

// File: tb/tb_hd_program_loader.sv
// Scoreboard bench for hd_program_loader: a registered-read HD model feeds the DUT and
// every expected instruction-memory write is queued up front and popped as im_we fires.
module tb_hd_program_loader;

   localparam logic [5:0] OP_BEGIN = 6'b010101;
   localparam logic [5:0] OP_END   = 6'b010110;
   localparam logic [5:0] OP_HDEND = 6'b011000;

   typedef struct packed {
      logic [8:0]  a;
      logic [31:0] d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  prog_idx = '0;
   logic [8:0]  hd_addr;
   logic [31:0] hd_q = '0;
   logic        im_we;
   logic [8:0]  im_addr;
   logic [31:0] im_data;
   logic        busy, done, error;
   logic [8:0]  prog_len;

   logic [31:0] hd_mem [512];
   wr_t         exp_q [$];
   wr_t         mon_w;
   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc = 0;
   int          s_edge = 0;
   int          done_cnt, err_cnt, done_edge, err_edge;

   hd_program_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .IDX_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .prog_idx(prog_idx),
      .hd_addr(hd_addr), .hd_q(hd_q), .im_we(im_we), .im_addr(im_addr),
      .im_data(im_data), .busy(busy), .done(done), .error(error), .prog_len(prog_len)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      hd_q <= hd_mem[hd_addr];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (im_we) begin
            if (exp_q.size() == 0) begin
               check("unexpected_im_we", 64'(im_addr), 64'h1_0000);
            end else begin
               mon_w = exp_q.pop_front();
               check("im_addr", 64'(im_addr), 64'(mon_w.a));
               check("im_data", 64'(im_data), 64'(mon_w.d));
            end
         end
         if (done)  begin done_cnt++; done_edge = cyc; end
         if (error) begin err_cnt++;  err_edge  = cyc; end
         if (done || error) check("done_error_exclusive", 64'(done & error), 64'd0);
      end
   end

   task automatic build_image(input int hd_end_at);
      logic [31:0] w;
      for (int i = 0; i < 512; i++) begin
         w = $urandom;
         if (w[31:26] inside {OP_BEGIN, OP_END, OP_HDEND}) w[31:26] = 6'd0;
         hd_mem[i] = w;
      end
      hd_mem[0]   = {OP_BEGIN, 26'h11};
      hd_mem[58]  = {OP_BEGIN, 26'h22};
      hd_mem[83]  = {OP_BEGIN, 26'h33};
      hd_mem[57]  = {OP_END, 26'd57};
      hd_mem[82]  = {OP_END, 26'd24};
      hd_mem[115] = {OP_END, 26'd32};
      hd_mem[116] = {OP_HDEND, 26'd0};
      if (hd_end_at >= 0) hd_mem[hd_end_at] = {OP_HDEND, 26'd0};
   endtask

   task automatic push_prog(input int lo, input int n);
      wr_t w;
      for (int i = 0; i < n; i++) begin
         w.a = 9'(i);
         w.d = hd_mem[lo + i];
         exp_q.push_back(w);
      end
   endtask

   task automatic do_load(input int idx, input bit pulse, input int exp_done, input int exp_err,
                          input int exp_rel, input int exp_len, input int budget);
      int k;
      done_cnt = 0; err_cnt = 0; done_edge = -1; err_edge = -1;
      @(negedge clk);
      start = 1'b1; prog_idx = 4'(idx); s_edge = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      if (pulse) prog_idx = 4'(idx + 1);
      k = 0;
      while (done_cnt + err_cnt == 0 && k < budget) begin
         @(negedge clk);
         if (pulse) start = (k < 40) ? ~start : 1'b0;
         k++;
      end
      start = 1'b0;
      if (k >= budget) check("timeout", 64'd1, 64'd0);
      repeat (8) @(negedge clk);
      check("done_count", 64'(done_cnt), 64'(exp_done));
      check("error_count", 64'(err_cnt), 64'(exp_err));
      if (exp_done > 0) check("done_edge", 64'(done_edge - s_edge), 64'(exp_rel));
      if (exp_err > 0)  check("error_edge", 64'(err_edge - s_edge), 64'(exp_rel));
      check("prog_len", 64'(prog_len), 64'(exp_len));
      check("busy_after", 64'(busy), 64'd0);
      check("writes_missing", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      build_image(-1);
      repeat (2) @(negedge clk);
      check("rst_hd_addr", 64'(hd_addr), 64'd0);
      check("rst_im_we", 64'(im_we), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done_error", 64'({done, error}), 64'd0);
      check("rst_prog_len", 64'(prog_len), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // program 0, then program 1
      push_prog(0, 58);
      do_load(0, 1'b0, 1, 0, 60, 58, 200);
      push_prog(58, 25);
      check("hd62_at_im4", 64'(exp_q[4].d), 64'(hd_mem[62]));
      do_load(1, 1'b0, 1, 0, 85, 25, 200);

      // nonexistent program 3 runs into HD_END
      do_load(3, 1'b0, 0, 1, 118, 0, 300);

      // HD_END inside program 0
      build_image(40);
      push_prog(0, 40);
      do_load(0, 1'b0, 0, 1, 42, 0, 200);

      // reset in the middle of a program-0 copy, then load program 2
      build_image(-1);
      done_cnt = 0; err_cnt = 0;
      push_prog(0, 18);
      @(negedge clk);
      start = 1'b1; prog_idx = 4'd0; s_edge = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 100 && cyc < s_edge + 19; k++) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_hd_addr", 64'(hd_addr), 64'd0);
      check("mid_rst_im_we", 64'(im_we), 64'd0);
      check("mid_rst_im_addr", 64'(im_addr), 64'd0);
      check("mid_rst_im_data", 64'(im_data), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_prog_len", 64'(prog_len), 64'd0);
      check("mid_rst_writes", 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_no_pulse", 64'(done_cnt + err_cnt), 64'd0);
      push_prog(83, 33);
      do_load(2, 1'b0, 1, 0, 118, 33, 300);

      // repeated start pulses while busy (prog_idx also changed mid-load)
      push_prog(0, 58);
      do_load(0, 1'b1, 1, 0, 60, 58, 200);

      // no terminator anywhere: copy runs up to the last address and errors
      for (int i = 1; i < 512; i++) begin
         if (hd_mem[i][31:26] inside {OP_BEGIN, OP_END, OP_HDEND}) hd_mem[i][31:26] = 6'd0;
      end
      push_prog(0, 511);
      do_load(0, 1'b0, 0, 1, 513, 0, 700);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hd_program_loader.md
HD_PROGRAM_LOADER -- requirements
Module: hd_program_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning HD and instruction-memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning HD and instruction-memory address width.
REQ-003 SHALL have parameter IDX_WIDTH, default 4, meaning program-index width.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, load request, sampled only in IDLE.
REQ-007 SHALL have port prog_idx, input, IDX_WIDTH, zero-based index of the requested program (n-th begin-file marker).
REQ-008 SHALL have port hd_addr, output, ADDR_WIDTH, registered HD read address.
REQ-009 SHALL have port hd_q, input, DATA_WIDTH, HD read data, valid the cycle after hd_addr is registered by the HD.
REQ-010 SHALL have port im_we, output, 1, instruction-memory write strobe.
REQ-011 SHALL have port im_addr, output, ADDR_WIDTH, instruction-memory write address.
REQ-012 SHALL have port im_data, output, DATA_WIDTH, instruction-memory write data.
REQ-013 SHALL have port busy, output, 1, high in SCAN and COPY.
REQ-014 SHALL have port done, output, 1, one-cycle success pulse.
REQ-015 SHALL have port error, output, 1, one-cycle failure pulse.
REQ-016 SHALL have port prog_len, output, ADDR_WIDTH, words copied, held until next start.

Function
REQ-017 SHALL decode opcode = word[31:26]: 010101 begin-file, 010110 end-file, 011000 HD_END; all others are payload.
REQ-018 SHALL implement states IDLE, SCAN, COPY, FIN, ERR.
REQ-019 SHALL, in IDLE with start=1, go to SCAN, set hd_addr=0, clear begin-counter and prog_len.
REQ-020 SHALL, in SCAN/COPY, increment hd_addr every cycle (streaming, one word per cycle); word at address A is evaluated at the second edge after hd_addr=A is driven.
REQ-021 SHALL, in SCAN, on begin-file with counter==prog_idx, record base B=A, register im_we=1, im_addr=0, im_data=word, enter COPY; on non-matching begin-file increment counter.
REQ-022 SHALL, in COPY, register im_we=1, im_addr=A-B, im_data=word for every word, end-file included.
REQ-023 SHALL, on end-file in COPY, set prog_len=A-B+1 and enter FIN; FIN asserts done for one cycle, then IDLE.
REQ-024 SHALL enter ERR on HD_END in SCAN or COPY, begin-file in COPY, or evaluation of address 2^ADDR_WIDTH-1 without termination; ERR asserts error for one cycle, no im_we, then IDLE.
REQ-025 SHALL drive im_we=0 in IDLE, FIN and ERR; words fetched past the terminator SHALL be discarded.
REQ-026 SHALL ignore start while busy=1.
REQ-027 SHALL make done and error mutually exclusive.

Reset
REQ-028 SHALL, on reset=1 at any time, force IDLE with hd_addr=0, im_we=0, im_addr=0, im_data=0, busy=0, done=0, error=0, prog_len=0.
REQ-029 SHALL, on reset mid-COPY, perform no further im_we; the next start SHALL restart the scan from address 0.

Verification
Standard image: begin-file at 0/58/83, end-file at 57 (imm 57)/82 (imm 24)/115 (imm 32), HD_END at 116; HD model has one-cycle registered read.
REQ-030 SHALL verify: start, prog_idx=0 -> 58 writes im[0..57] equal HD[0..57], done high 60 edges after start edge, prog_len=58.
REQ-031 SHALL verify: prog_idx=1 -> im[0..24] equal HD[58..82], im[4] equals HD[62], prog_len=25, done at edge 85.
REQ-032 SHALL verify: prog_idx=3 -> no im_we, error pulse at edge 118, prog_len=0, busy low after.
REQ-033 SHALL verify: image with HD_END at 40 inside program 0 -> im writes 0..39 only, then error, no done.
REQ-034 SHALL verify: reset asserted at edge 20 of an idx-0 load -> outputs at reset values immediately, no further im_we; new start with idx 2 -> prog_len=33, im[0]=HD[83].
REQ-035 SHALL verify: start pulsed repeatedly during busy -> single load, single done pulse.
